// File: rtl/flash_fetch.sv
// flash_fetch: byte-read front end for the serial flash reader.
// Serves CPU/loader byte requests (req/ack) from one line buffer of
// LINE_BYTES consecutive flash bytes. On a miss it refills the aligned line
// one byte at a time through the SPI read engine, then acknowledges.
//
// Ports
//   sclk, rst        clock (rising edge), async active-high reset
//   req_i, addr_i    byte request (level, held until ack) and byte address
//   flush_i          single-cycle pulse, invalidates the line buffer
//   ack_o, rdata_o   one-cycle ack; rdata holds until the next ack
//   busy_o           high while a line refill is in progress
//   spi_ready_o      start request to the SPI reader
//   spi_address_o    byte address for the SPI reader
//   spi_data_i       byte returned by the SPI reader
//   spi_cs_i         SPI chip select, 0 = transaction in flight
//
// state     | meaning
// IDLE      | waiting for a request; hits answered directly from the line
// WAIT_LOW  | spi_ready raised, waiting for the reader to drop cs
// WAIT_HIGH | byte transfer in flight, waiting for cs to rise
// DONE      | ack cycle; req ignored so a late-dropping req cannot retrigger
module flash_fetch #(
   parameter int LINE_BYTES = 4
) (
   input  logic        sclk,
   input  logic        rst,
   input  logic        req_i,
   input  logic [15:0] addr_i,
   input  logic        flush_i,
   output logic        ack_o,
   output logic [7:0]  rdata_o,
   output logic        busy_o,
   output logic        spi_ready_o,
   output logic [15:0] spi_address_o,
   input  logic [7:0]  spi_data_i,
   input  logic        spi_cs_i
);

   localparam int IDX_W = (LINE_BYTES > 1) ? $clog2(LINE_BYTES) : 1;
   localparam logic [15:0]      OFS_MASK = 16'(LINE_BYTES - 1);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LINE_BYTES - 1);

   typedef enum logic [1:0] {IDLE, WAIT_LOW, WAIT_HIGH, DONE} state_t;

   state_t           state_q, state_d;
   logic             valid_q, valid_d;
   logic [15:0]      tag_q, tag_d;
   logic [7:0]       line_q [LINE_BYTES];
   logic [7:0]       line_d [LINE_BYTES];
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [IDX_W-1:0] off_q, off_d;
   logic             flush_pend_q, flush_pend_d;
   logic             ack_q, ack_d;
   logic [7:0]       rdata_q, rdata_d;
   logic             busy_q, busy_d;
   logic             spi_ready_q, spi_ready_d;
   logic [15:0]      spi_address_q, spi_address_d;

   logic [15:0]      req_base;
   logic [IDX_W-1:0] req_off;
   logic             hit;

   assign req_base = addr_i & ~OFS_MASK;
   assign req_off  = addr_i[IDX_W-1:0] & LAST_IDX;
   assign hit      = valid_q && !flush_i && (req_base == tag_q);

   always_comb begin
      state_d       = state_q;
      valid_d       = valid_q;
      tag_d         = tag_q;
      line_d        = line_q;
      idx_d         = idx_q;
      off_d         = off_q;
      flush_pend_d  = flush_pend_q;
      ack_d         = 1'b0;
      rdata_d       = rdata_q;
      busy_d        = busy_q;
      spi_ready_d   = spi_ready_q;
      spi_address_d = spi_address_q;

      case (state_q)
         IDLE: begin
            if (req_i) begin
               if (hit) begin
                  ack_d   = 1'b1;
                  rdata_d = line_q[req_off];
                  state_d = DONE;
               end else begin
                  valid_d       = 1'b0;
                  tag_d         = req_base;
                  idx_d         = '0;
                  off_d         = req_off;
                  busy_d        = 1'b1;
                  spi_address_d = req_base;
                  spi_ready_d   = 1'b1;
                  state_d       = WAIT_LOW;
               end
            end else if (flush_i) begin
               valid_d = 1'b0;
            end
         end
         WAIT_LOW: begin
            if (flush_i) flush_pend_d = 1'b1;
            // Drop ready as soon as the reader starts so it cannot launch
            // a second transaction when it returns to idle.
            if (!spi_cs_i) begin
               spi_ready_d = 1'b0;
               state_d     = WAIT_HIGH;
            end
         end
         WAIT_HIGH: begin
            if (flush_i) flush_pend_d = 1'b1;
            if (spi_cs_i) begin
               line_d[idx_q] = spi_data_i;
               if (idx_q != LAST_IDX) begin
                  idx_d         = idx_q + IDX_W'(1);
                  spi_address_d = spi_address_q + 16'd1;
                  spi_ready_d   = 1'b1;
                  state_d       = WAIT_LOW;
               end else begin
                  // A flush arriving on the final capture cycle also counts.
                  valid_d = !(flush_pend_q || flush_i);
                  busy_d  = 1'b0;
                  ack_d   = 1'b1;
                  rdata_d = (off_q == LAST_IDX) ? spi_data_i : line_q[off_q];
                  state_d = DONE;
               end
            end
         end
         DONE: begin
            flush_pend_d = 1'b0;
            if (flush_i) valid_d = 1'b0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge sclk or posedge rst) begin
      if (rst) begin
         state_q       <= IDLE;
         valid_q       <= 1'b0;
         tag_q         <= '0;
         line_q        <= '{default: '0};
         idx_q         <= '0;
         off_q         <= '0;
         flush_pend_q  <= 1'b0;
         ack_q         <= 1'b0;
         rdata_q       <= '0;
         busy_q        <= 1'b0;
         spi_ready_q   <= 1'b0;
         spi_address_q <= '0;
      end else begin
         state_q       <= state_d;
         valid_q       <= valid_d;
         tag_q         <= tag_d;
         line_q        <= line_d;
         idx_q         <= idx_d;
         off_q         <= off_d;
         flush_pend_q  <= flush_pend_d;
         ack_q         <= ack_d;
         rdata_q       <= rdata_d;
         busy_q        <= busy_d;
         spi_ready_q   <= spi_ready_d;
         spi_address_q <= spi_address_d;
      end
   end

   assign ack_o         = ack_q;
   assign rdata_o       = rdata_q;
   assign busy_o        = busy_q;
   assign spi_ready_o   = spi_ready_q;
   assign spi_address_o = spi_address_q;

endmodule

// File: doc/flash_fetch.md
# flash_fetch

Byte-read front end for the serial flash reader: accepts CPU/loader byte requests on a req/ack handshake. Serves them from a single line buffer of LINE_BYTES consecutive flash bytes. On a miss, drives the downstream SPI flash read engine (ready/address in, data/cs out) once per byte to refill the aligned line, then acknowledges. Sits directly upstream of the SPI reader, on the same sclk.

## Interface

- LINE_BYTES, 4, bytes per line; power of two, 1..16; line base = addr with low log2(LINE_BYTES) bits cleared
- sclk  in  1  clock; all logic on rising edge
- rst  in  1  reset, asynchronous, active-high
- req  in  1  byte read request; level, held until ack
- addr  in  16  byte address; stable while req=1, sampled at acceptance
- flush  in  1  single-cycle pulse; invalidates the line buffer
- ack  out  1  one-cycle pulse; rdata valid in the same cycle
- rdata  out  8  returned byte; holds value until next ack
- busy  out  1  high while a line refill is in progress
- spi_ready  out  1  start request to the SPI reader
- spi_address  out  16  byte address for the SPI reader; stable while spi_ready=1 and while spi_cs=0
- spi_data  in  8  byte from the SPI reader
- spi_cs  in  1  SPI chip select (registered on sclk); 0 = transaction in flight

## Operation

- Reset values: ack=0, rdata=0, busy=0, spi_ready=0, spi_address=0, state=IDLE, valid=0, tag=0, all line bytes=0, byte_idx=0, flush_pending=0.
- Hit condition: valid=1, flush=0 this cycle, addr line base == tag.
- States: IDLE, WAIT_LOW, WAIT_HIGH, DONE.
- IDLE, req=0: if flush, valid<=0.
- IDLE, req=1, hit: ack<=1, rdata<=line[offset], go DONE.
- IDLE, req=1, miss:
  - valid<=0, tag<=line base, byte_idx<=0, busy<=1
  - spi_address<=line base, spi_ready<=1
  - go WAIT_LOW
- WAIT_LOW, spi_cs=0: spi_ready<=0, go WAIT_HIGH. spi_ready must be low before the SPI reader returns to idle, so that no second transaction starts.
- WAIT_HIGH, spi_cs=1: line[byte_idx]<=spi_data.
  - Not the last byte: byte_idx++, spi_address++, spi_ready<=1, go WAIT_LOW.
  - Last byte (LINE_BYTES-1): valid<=~flush_pending, busy<=0, ack<=1, go DONE. rdata<=requested byte, bypassing spi_data when offset==last.
- DONE: ack<=0, flush_pending<=0, go IDLE. req is ignored in DONE, so a requester dropping req one cycle after ack does not retrigger.
- flush in WAIT_LOW/WAIT_HIGH sets flush_pending:
  - the current refill still completes and ack is delivered with correct data
  - the line is left invalid
- flush in DONE: valid<=0.
- Address arithmetic is 16-bit. spi_address increments only within a line, so it never wraps. Line 0xFFFC..0xFFFF with LINE_BYTES=4 is legal.
- rst mid-refill: all state returns to reset values immediately; the SPI reader shares rst.

## Timing

- Hit: req sampled at edge R -> ack=1 and rdata valid after R (1-cycle latency).
- Per-byte SPI exchange is 34 edges from spi_ready asserted (edge E0) to byte capture (E34):
  - reader starts at E1 (cs 0); fetch drops spi_ready at E2
  - reader raises cs at E33; fetch captures at E34 and re-asserts spi_ready at E34 for the next byte
- Miss: req sampled at edge R -> ack after edge R+34*LINE_BYTES (R+136 for default).
- Back-to-back requests: a new req is accepted no earlier than 2 edges after the ack edge.

## Test plan

- Reset: assert rst mid-cycle -> all outputs 0 without a clock edge; spi_ready=0 keeps the reader idle (cs=1).
- Miss at addr=0x1235, flash model byte=low address byte:
  - SPI model sees four 0x03 reads at 0x1234, 0x1235, 0x1236, 0x1237
  - ack 136 edges after req acceptance, rdata=0x35
  - busy high throughout
- Hit after that miss: req addr=0x1237 -> ack on next edge, rdata=0x37, spi_ready stays 0.
- flush pulse, then req addr=0x1234 -> full refill, ack at +136, rdata=0x34.
- flush during the third byte of a refill:
  - ack still delivered with correct byte
  - immediate re-request of the same line refills (136 edges)
- rst asserted at edge +50 of a refill -> spi_ready=0, busy=0, valid=0; fresh req to 0xFFFE refills 0xFFFC..0xFFFF with no address wrap, rdata=0xFE.
